// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell walked across a WIDTH-bit add, LSB first.
// Optional SERIAL_ADD_SUB_EN adds a 'sub' port for two's-complement subtraction.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic             r_c_ff;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_load;

  // Subtraction is a + ~b + 1; the carry flop doubles as the +1.
`ifdef SERIAL_ADD_SUB_EN
  assign w_b_load = sub ? ~b : b;
  assign w_c_load = sub ? 1'b1 : cin;
`else
  assign w_b_load = b;
  assign w_c_load = cin;
`endif

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  full_adder u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_c_ff),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
          w_load      = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, serial shift, and result publish on the final bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_c_ff  <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_load) begin
        r_a_sh <= a;
        r_b_sh <= w_b_load;
        r_c_ff <= w_c_load;
        r_cnt  <= '0;
      end else if (r_state == S_SHIFT) begin
        r_a_sh <= r_a_sh >> 1;
        r_b_sh <= r_b_sh >> 1;
        r_s_sh <= {w_fa_s, r_s_sh[WIDTH-1:1]};
        r_c_ff <= w_fa_c;
        r_cnt  <= r_cnt + CW'(1);
        if (w_last) begin
          r_sum   <= {w_fa_s, r_s_sh[WIDTH-1:1]};
          r_carry <= w_fa_c;
        end
      end
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  assign sum   = r_sum;
  assign carry = r_carry;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule
